// File: rtl/pong_pkg.sv
// Shared definitions for the pong renderer: state encoding, colour words and
// frame counts used by the game FSM.
package pong_pkg;

  localparam int PX_W = 30;
  typedef logic [PX_W-1:0] px_t;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } state_e;

  localparam logic [1:0] S_SERVE = ST_SERVE;
  localparam logic [1:0] S_PLAY  = ST_PLAY;
  localparam logic [1:0] S_MISS  = ST_MISS;

  localparam px_t C_WHITE = 30'h3FFF_FFFF;
  localparam px_t C_GREEN = {10'd0, 10'h3FF, 10'd0};
  localparam px_t C_RED   = {10'h3FF, 20'd0};
  localparam px_t C_BLUE  = {20'd0, 10'h3FF};
  localparam px_t C_BLACK = '0;

  localparam int SERVE_FRAMES = 60;
  localparam int MISS_FRAMES  = 30;
  localparam int BORDER_PX    = 4;

endpackage

// File: rtl/pong_renderer_if.sv
// Pixel-side bundle between the timing generator / controls and the renderer.
interface pong_renderer_if;
  import pong_pkg::*;

  logic [10:0] px_h;
  logic [10:0] px_v;
  logic        btn_up;
  logic        btn_dn;
  px_t         px_data;
  logic [7:0]  score;
  logic        miss;

  modport master (
    output px_h, px_v, btn_up, btn_dn,
    input  px_data, score, miss
  );

  modport slave (
    input  px_h, px_v, btn_up, btn_dn,
    output px_data, score, miss
  );
endinterface

// File: rtl/pong_paddle.sv
// Paddle vertical position: steps once per frame tick, clamped to the screen.
module pong_paddle #(
  parameter int V_ACT     = 480,
  parameter int PAD_H     = 64,
  parameter int PAD_SPEED = 4
) (
  input  logic        px_clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_dn,
  output logic [10:0] pad_y
);
  localparam logic [10:0] PAD_MAX = 11'(V_ACT - PAD_H);
  localparam logic [10:0] PAD_RST = 11'((V_ACT - PAD_H) / 2);
  localparam logic [10:0] STEP    = 11'(PAD_SPEED);

  logic [10:0] pad_y_q, pad_y_d;

  always_comb begin
    // NOTE: default-assign every always_comb output first so no path infers a latch.
    pad_y_d = pad_y_q;
    if (frame_tick) begin
      if (btn_up && !btn_dn)
        pad_y_d = (pad_y_q < STEP) ? 11'd0 : pad_y_q - STEP;
      else if (btn_dn && !btn_up)
        pad_y_d = (pad_y_q > PAD_MAX - STEP) ? PAD_MAX : pad_y_q + STEP;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge px_clk) begin
    if (rst) pad_y_q <= PAD_RST;
    else     pad_y_q <= pad_y_d;
  end

  assign pad_y = pad_y_q;
endmodule

// File: rtl/pong_renderer.sv
// Pong game state machine and zero-latency pixel colouring.
// Optional SCORE_BAR_EN macro draws the score as a blue bar along the top rows.
module pong_renderer
  import pong_pkg::*;
#(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int BALL_SZ   = 8,
  parameter int PAD_X     = 16,
  parameter int PAD_W     = 8,
  parameter int PAD_H     = 64,
  parameter int SPEED     = 2,
  parameter int PAD_SPEED = 4
) (
  input logic            px_clk,
  input logic            rst,
  pong_renderer_if.slave bus
);
  localparam logic [10:0] H_LAST = 11'(H_ACT - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACT - 1);
  localparam logic [10:0] HA     = 11'(H_ACT);
  localparam logic [10:0] VA     = 11'(V_ACT);
  localparam logic [10:0] BSZ    = 11'(BALL_SZ);
  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] PAD_L  = 11'(PAD_X);
  localparam logic [10:0] PAD_R  = 11'(PAD_X + PAD_W);
  localparam logic [10:0] PAD_HT = 11'(PAD_H);
  localparam logic [10:0] X_CTR  = 11'(H_ACT / 2 - BALL_SZ / 2);
  localparam logic [10:0] Y_CTR  = 11'(V_ACT / 2 - BALL_SZ / 2);
  localparam logic [10:0] X_MAX  = 11'(H_ACT - BALL_SZ);
  localparam logic [10:0] Y_MAX  = 11'(V_ACT - BALL_SZ);
  localparam logic [10:0] BRD    = 11'(BORDER_PX);
  localparam logic [10:0] H_BRD  = 11'(H_ACT - BORDER_PX);
  localparam logic [10:0] V_BRD  = 11'(V_ACT - BORDER_PX);
  localparam logic [6:0]  SERVE_LAST = 7'(SERVE_FRAMES - 1);
  localparam logic [6:0]  MISS_LAST  = 7'(MISS_FRAMES - 1);

  logic        frame_tick_q, frame_tick_d;
  logic [1:0]  state_q, state_d;
  logic [6:0]  fcnt_q, fcnt_d;
  logic [10:0] ball_x_q, ball_x_d;
  logic [10:0] ball_y_q, ball_y_d;
  logic        dx_neg_q, dx_neg_d;
  logic        dy_neg_q, dy_neg_d;
  logic [7:0]  score_q, score_d;
  logic [10:0] pad_y;
  logic        overlap;

  pong_paddle #(
    .V_ACT    (V_ACT),
    .PAD_H    (PAD_H),
    .PAD_SPEED(PAD_SPEED)
  ) u_paddle (
    .px_clk    (px_clk),
    .rst       (rst),
    .frame_tick(frame_tick_q),
    .btn_up    (bus.btn_up),
    .btn_dn    (bus.btn_dn),
    .pad_y     (pad_y)
  );

  always_comb begin
    frame_tick_d = (bus.px_h == H_LAST) && (bus.px_v == V_LAST);
    overlap      = (ball_y_q < pad_y + PAD_HT) && (pad_y < ball_y_q + BSZ);
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    score_d  = score_q;

    if (frame_tick_q) begin
      case (state_q)
        S_SERVE: begin
          ball_x_d = X_CTR;
          ball_y_d = Y_CTR;
          dx_neg_d = 1'b0;
          dy_neg_d = 1'b0;
          if (fcnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 7'd1;
          end
        end

        S_PLAY: begin
          // Each axis resolves its own wall/paddle event independently.
          if (dy_neg_q) begin
            if (ball_y_q < SPD) begin
              ball_y_d = '0;
              dy_neg_d = 1'b0;
            end else begin
              ball_y_d = ball_y_q - SPD;
            end
          end else if (ball_y_q + BSZ + SPD > VA) begin
            ball_y_d = Y_MAX;
            dy_neg_d = 1'b1;
          end else begin
            ball_y_d = ball_y_q + SPD;
          end

          if (!dx_neg_q) begin
            if (ball_x_q + BSZ + SPD > HA) begin
              ball_x_d = X_MAX;
              dx_neg_d = 1'b1;
            end else begin
              ball_x_d = ball_x_q + SPD;
            end
          end else if (ball_x_q < PAD_R + SPD) begin
            if (ball_x_q >= PAD_L && overlap) begin
              ball_x_d = PAD_R;
              dx_neg_d = 1'b0;
              score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end else begin
              // A miss freezes the whole ball, overriding the vertical step.
              state_d  = S_MISS;
              fcnt_d   = '0;
              ball_y_d = ball_y_q;
              dy_neg_d = dy_neg_q;
            end
          end else begin
            ball_x_d = ball_x_q - SPD;
          end
        end

        S_MISS: begin
          if (fcnt_q == MISS_LAST) begin
            state_d  = S_SERVE;
            fcnt_d   = '0;
            ball_x_d = X_CTR;
            ball_y_d = Y_CTR;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b0;
          end else begin
            fcnt_d = fcnt_q + 7'd1;
          end
        end

        default: begin
          state_d = S_SERVE;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      frame_tick_q <= 1'b0;
      state_q      <= S_SERVE;
      fcnt_q       <= '0;
      ball_x_q     <= X_CTR;
      ball_y_q     <= Y_CTR;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      score_q      <= '0;
    end else begin
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dx_neg_q     <= dx_neg_d;
      dy_neg_q     <= dy_neg_d;
      score_q      <= score_d;
    end
  end

  logic in_ball, in_pad, in_border, in_bar;
  px_t  px_d;

  always_comb begin
    in_ball = (bus.px_h >= ball_x_q) && (bus.px_h < ball_x_q + BSZ) &&
              (bus.px_v >= ball_y_q) && (bus.px_v < ball_y_q + BSZ);
    in_pad  = (bus.px_h >= PAD_L) && (bus.px_h < PAD_R) &&
              (bus.px_v >= pad_y) && (bus.px_v < pad_y + PAD_HT);
    in_border = (state_q == S_MISS) &&
                ((bus.px_h < BRD) || (bus.px_h >= H_BRD) ||
                 (bus.px_v < BRD) || (bus.px_v >= V_BRD));
`ifdef SCORE_BAR_EN
    in_bar = (bus.px_v < BRD) && (bus.px_h < {2'b00, score_q, 1'b0});
`else
    in_bar = 1'b0;
`endif
    if (in_ball)        px_d = C_WHITE;
    else if (in_bar)    px_d = C_BLUE;
    else if (in_pad)    px_d = C_GREEN;
    else if (in_border) px_d = C_RED;
    else                px_d = C_BLACK;
  end

  assign bus.px_data = px_d;
  assign bus.score   = score_q;
  assign bus.miss    = (state_q == S_MISS);
endmodule

// File: tb/tb_pong_renderer.sv
// Self-checking bench: randomized/tracked play against a frame-level game model.
module tb_pong_renderer;
  import pong_pkg::*;

  localparam int V_ACT     = 480;
  localparam int BALL_SZ   = 8;
  localparam int PAD_X     = 16;
  localparam int PAD_W     = 8;
  localparam int PAD_H     = 64;
  localparam int SPEED     = 2;
  localparam int PAD_SPEED = 4;
  localparam int HA_A      = 640;
  localparam int HA_B      = 96;

  localparam logic [29:0] WHITE = 30'h3FFFFFFF;
  localparam logic [29:0] GREEN = 30'h000FFC00;
  localparam logic [29:0] RED   = 30'h3FF00000;
  localparam logic [29:0] BLUE  = 30'h000003FF;

  typedef enum int {M_SERVE, M_PLAY, M_MISS} mst_e;
  typedef struct {
    int   x, y, dx, dy, pad, score, fcnt;
    mst_e st;
  } mdl_t;

  logic px_clk = 1'b0;
  logic rst_a, rst_b;
  always #5 px_clk = ~px_clk;

  pong_renderer_if if_a ();
  pong_renderer_if if_b ();

  pong_renderer #(.H_ACT(HA_A)) dut_a (.px_clk(px_clk), .rst(rst_a), .bus(if_a.slave));
  pong_renderer #(.H_ACT(HA_B)) dut_b (.px_clk(px_clk), .rst(rst_b), .bus(if_b.slave));

  int   checks = 0;
  int   errors = 0;
  mdl_t ma, mb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t centre(mdl_t m, int h_act);
    mdl_t n = m;
    n.x  = h_act / 2 - BALL_SZ / 2;
    n.y  = V_ACT / 2 - BALL_SZ / 2;
    n.dx = 1;
    n.dy = 1;
    return n;
  endfunction

  function automatic mdl_t mdl_reset(int h_act);
    mdl_t n;
    n.pad = 208; n.score = 0; n.fcnt = 0; n.st = M_SERVE;
    n.x = 0; n.y = 0; n.dx = 0; n.dy = 0;
    return centre(n, h_act);
  endfunction

  // One frame of game rules, written on signed integers and velocity signs.
  function automatic mdl_t step(mdl_t m, bit up, bit dn, int h_act);
    mdl_t n = m;
    int   nx, ny;
    bit   ovl;
    if (up && !dn)      n.pad = (m.pad - PAD_SPEED < 0) ? 0 : m.pad - PAD_SPEED;
    else if (dn && !up) n.pad = (m.pad + PAD_SPEED > V_ACT - PAD_H) ? V_ACT - PAD_H : m.pad + PAD_SPEED;
    case (m.st)
      M_SERVE: begin
        n = centre(n, h_act);
        if (m.fcnt == 59) begin n.st = M_PLAY; n.fcnt = 0; end
        else n.fcnt = m.fcnt + 1;
      end
      M_PLAY: begin
        ny = m.y + m.dy * SPEED;
        if (ny < 0) begin ny = 0; n.dy = 1; end
        else if (ny + BALL_SZ > V_ACT) begin ny = V_ACT - BALL_SZ; n.dy = -1; end
        nx = m.x + m.dx * SPEED;
        n.x = nx;
        n.y = ny;
        if (m.dx > 0 && nx + BALL_SZ > h_act) begin
          n.x = h_act - BALL_SZ; n.dx = -1;
        end else if (m.dx < 0 && nx < PAD_X + PAD_W) begin
          ovl = (m.y < m.pad + PAD_H) && (m.pad < m.y + BALL_SZ);
          if (m.x >= PAD_X && ovl) begin
            n.x = PAD_X + PAD_W; n.dx = 1;
            if (m.score < 255) n.score = m.score + 1;
          end else begin
            n.st = M_MISS; n.fcnt = 0; n.x = m.x; n.y = m.y; n.dy = m.dy;
          end
        end
      end
      default: begin
        if (m.fcnt == 29) begin n = centre(n, h_act); n.st = M_SERVE; n.fcnt = 0; end
        else n.fcnt = m.fcnt + 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [29:0] px_ref(mdl_t m, int h, int v, int h_act);
    if (h >= m.x && h < m.x + BALL_SZ && v >= m.y && v < m.y + BALL_SZ) return WHITE;
`ifdef SCORE_BAR_EN
    if (v < 4 && h < 2 * m.score) return BLUE;
`endif
    if (h >= PAD_X && h < PAD_X + PAD_W && v >= m.pad && v < m.pad + PAD_H) return GREEN;
    if (m.st == M_MISS && (h < 4 || h >= h_act - 4 || v < 4 || v >= V_ACT - 4)) return RED;
    return 30'd0;
  endfunction

  function automatic logic [1:0] st_code(mdl_t m);
    case (m.st)
      M_SERVE: return S_SERVE;
      M_PLAY:  return S_PLAY;
      default: return S_MISS;
    endcase
  endfunction

  // Paddle controller: follow the ball (follow=1) or run away from it.
  task automatic steer(input mdl_t m, input bit follow, output bit up, output bit dn);
    int pc, bc;
    pc = m.pad + PAD_H / 2;
    bc = m.y + BALL_SZ / 2;
    up = 1'b0;
    dn = 1'b0;
    if (follow) begin
      if (pc < bc) dn = 1'b1; else if (pc > bc) up = 1'b1;
    end else begin
      if (pc < bc) up = 1'b1; else dn = 1'b1;
    end
  endtask

  // Called at a negedge; returns at a negedge after the tick has been applied.
  task automatic tick_a(input bit up, input bit dn);
    if_a.px_h = 11'(HA_A - 1); if_a.px_v = 11'(V_ACT - 1);
    if_a.btn_up = up; if_a.btn_dn = dn;
    @(negedge px_clk);
    if_a.px_h = '0; if_a.px_v = '0;
    @(negedge px_clk);
    ma = step(ma, up, dn, HA_A);
  endtask

  task automatic tick_b(input bit up, input bit dn);
    if_b.px_h = 11'(HA_B - 1); if_b.px_v = 11'(V_ACT - 1);
    if_b.btn_up = up; if_b.btn_dn = dn;
    @(negedge px_clk);
    if_b.px_h = '0; if_b.px_v = '0;
    @(negedge px_clk);
    mb = step(mb, up, dn, HA_B);
  endtask

  task automatic px_a(input string tag, input int h, input int v);
    if_a.px_h = 11'(h); if_a.px_v = 11'(v);
    #1;
    check(tag, 32'(if_a.px_data), 32'(px_ref(ma, h, v, HA_A)));
  endtask

  task automatic verify_a(input string tag);
    check({tag, ".x"},     32'(dut_a.ball_x_q), 32'(ma.x));
    check({tag, ".y"},     32'(dut_a.ball_y_q), 32'(ma.y));
    check({tag, ".state"}, 32'(dut_a.state_q),  32'(st_code(ma)));
    check({tag, ".pad"},   32'(dut_a.u_paddle.pad_y_q), 32'(ma.pad));
    check({tag, ".score"}, 32'(if_a.score), 32'(ma.score));
    check({tag, ".miss"},  32'(if_a.miss),  32'(ma.st == M_MISS));
    px_a({tag, ".px_ball"}, ma.x + BALL_SZ - 1, ma.y + BALL_SZ - 1);
    if (ma.st == M_MISS) px_a({tag, ".px_border"}, 0, 0);
    else px_a({tag, ".px_rand"}, $urandom_range(0, HA_A - 2), $urandom_range(0, V_ACT - 1));
  endtask

  initial begin
    bit up, dn;
    int post;
    bit bar_done;
    if_a.px_h = '0; if_a.px_v = '0; if_a.btn_up = 1'b0; if_a.btn_dn = 1'b0;
    if_b.px_h = '0; if_b.px_v = '0; if_b.btn_up = 1'b0; if_b.btn_dn = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge px_clk);
    ma = mdl_reset(HA_A);
    mb = mdl_reset(HA_B);
    check("rst.tick", 32'(dut_a.frame_tick_q), 32'd0);
    check("rst.fcnt", 32'(dut_a.fcnt_q), 32'd0);
    check("rst.ball_x", 32'(dut_a.ball_x_q), 32'd316);
    check("rst.ball_y", 32'(dut_a.ball_y_q), 32'd236);
    verify_a("rst");
    px_a("rst.px_pad", PAD_X, 208);
    rst_a = 1'b0; rst_b = 1'b0;

    // Serve countdown: still serving after 59 ticks, playing at tick 60.
    repeat (59) tick_a(1'b0, 1'b0);
    verify_a("serve59");
    tick_a(1'b0, 1'b0);
    verify_a("serve60");
    check("serve60.play", 32'(dut_a.state_q), 32'(S_PLAY));
    tick_a(1'b0, 1'b0);
    verify_a("play1");

    // Paddle runs to the top and clamps; both buttons hold.
    for (int i = 1; i <= 60; i++) begin
      tick_a(1'b1, 1'b0);
      if (i == 52 || i == 60) check("pad_top", 32'(dut_a.u_paddle.pad_y_q), 32'd0);
    end
    repeat (5) tick_a(1'b1, 1'b1);
    verify_a("pad_both");
    repeat (3) tick_a(1'b0, 1'b1);
    verify_a("pad_dn");

    // Tracked rallies first (paddle hits), then evasive play (misses, re-serve).
    for (int i = 0; i < 2200; i++) begin
      if (i < 1300) steer(ma, 1'b1, up, dn);
      else if (($urandom % 4) == 0) begin up = 1'($urandom); dn = 1'($urandom); end
      else steer(ma, 1'b0, up, dn);
      tick_a(up, dn);
      verify_a("play");
    end

    // Reset landing on the frame-tick pixel must win and clear the tick.
    repeat (7) tick_a(1'b0, 1'b1);
    if_a.px_h = 11'(HA_A - 1); if_a.px_v = 11'(V_ACT - 1);
    rst_a = 1'b1;
    @(negedge px_clk);
    if_a.px_h = '0; if_a.px_v = '0;
    ma = mdl_reset(HA_A);
    check("midrst.tick", 32'(dut_a.frame_tick_q), 32'd0);
    verify_a("midrst");
    rst_a = 1'b0;
    @(negedge px_clk);

    // Narrow court: track until score saturates, then keep scoring.
    post = 0;
    bar_done = 1'b0;
    for (int i = 0; i < 20000 && post < 300; i++) begin
      steer(mb, 1'b1, up, dn);
      tick_b(up, dn);
      check("b.score", 32'(if_b.score), 32'(mb.score));
      check("b.x", 32'(dut_b.ball_x_q), 32'(mb.x));
      check("b.state", 32'(dut_b.state_q), 32'(st_code(mb)));
`ifdef SCORE_BAR_EN
      if (mb.score == 3 && !bar_done) begin
        bar_done = 1'b1;
        if_b.px_h = 11'd5; if_b.px_v = 11'd2; #1;
        check("bar.5_2", 32'(if_b.px_data), 32'(BLUE));
        if_b.px_h = 11'd6; #1;
        check("bar.6_2", 32'(if_b.px_data), 32'd0);
      end
`endif
      if (mb.score == 255) post++;
    end
    check("score_sat", 32'(if_b.score), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
